// File: rtl/perif_pkg.sv
// Shared peripheral constants: FSM encoding and default widths.
// Used by the write demux and shared with the peripheral read mux.
package perif_pkg;

  localparam int PERIF_T = 32;
  localparam int PERIF_R = 2;
  localparam int PERIF_N = 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACK  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  function automatic logic [1:0] st_after_ack(
    input logic req
  );
    return req ? ST_HOLD : ST_IDLE;
  endfunction

endpackage

// File: rtl/perif_write_demux_if.sv
// Store-side bus between ARC datapath (master) and write demux (slave).
// Signals: selection, datain, wr_req, wr_ack, dataout, update, err
// (+ rdback when PERIF_WR_READBACK_EN is defined).
interface perif_write_demux_if
  import perif_pkg::*;
#(
  parameter int R = PERIF_R,
  parameter int T = PERIF_T,
  parameter int N = PERIF_N
);

  logic [N-1:0]   selection;
  logic [T-1:0]   datain;
  logic           wr_req;
  logic           wr_ack;
  logic [R*T-1:0] dataout;
  logic [R-1:0]   update;
  logic           err;
`ifdef PERIF_WR_READBACK_EN
  logic [T-1:0]   rdback;

  modport master (
    output selection, datain, wr_req,
    input  wr_ack, dataout, update, err, rdback
  );

  modport slave (
    input  selection, datain, wr_req,
    output wr_ack, dataout, update, err, rdback
  );
`else
  modport master (
    output selection, datain, wr_req,
    input  wr_ack, dataout, update, err
  );

  modport slave (
    input  selection, datain, wr_req,
    output wr_ack, dataout, update, err
  );
`endif

endinterface

// File: rtl/perif_reg_slot.sv
// One T-bit peripheral output register with load enable.
// Ports: clk, rst_n (async low), load_i, d_i, q_o.
module perif_reg_slot
  import perif_pkg::*;
#(
  parameter int T = PERIF_T
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [T-1:0] d_i,
  output logic [T-1:0] q_o
);

  logic [T-1:0] data_q;
  logic [T-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load_i) data_d = d_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign q_o = data_q;

endmodule

// File: rtl/perif_write_demux.sv
// Peripheral write demux: 4-phase req/ack store into one of R registers.
// Ports: clk, rst_n, bus (slave modport); optional PERIF_WR_READBACK_EN.
module perif_write_demux
  import perif_pkg::*;
#(
  parameter int R = PERIF_R,
  parameter int T = PERIF_T,
  parameter int N = PERIF_N
) (
  input  logic                 clk,
  input  logic                 rst_n,
  perif_write_demux_if.slave   bus
);

  logic [1:0]   state_q;
  logic [1:0]   state_d;
  logic         ack_q;
  logic         ack_d;
  logic [R-1:0] upd_q;
  logic [R-1:0] upd_d;
  logic         err_q;
  logic         err_d;
  logic [R-1:0] dec;
  logic [R-1:0] load;
  logic         accept;
  logic [T-1:0] slot_q [R];
  logic [R*T-1:0] dout;

  // One-hot decode; all zero when selection is out of range.
  always_comb begin
    dec = '0;
    for (int k = 0; k < R; k++) begin
      dec[k] = (32'(bus.selection) == k);
    end
  end

  assign accept = (state_q == ST_IDLE) && bus.wr_req;
  assign load   = dec & {R{accept}};

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    upd_d   = '0;
    err_d   = 1'b0;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        ack_d = 1'b0;
        if (bus.wr_req) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          upd_d   = dec;
          err_d   = ~|dec;
        end
      end
      (state_q == ST_ACK): begin
        state_d = st_after_ack(bus.wr_req);
        ack_d   = bus.wr_req;
      end
      (state_q == ST_HOLD): begin
        ack_d = bus.wr_req;
        if (!bus.wr_req) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        ack_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      upd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
    end
  end

  for (genvar k = 0; k < R; k++) begin : g_slot
    perif_reg_slot #(
      .T(T)
    ) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load_i(load[k]),
      .d_i   (bus.datain),
      .q_o   (slot_q[k])
    );
  end

  // Lane k sits at dataout[k*T +: T], same order as the read mux.
  always_comb begin
    dout = '0;
    for (int k = 0; k < R; k++) begin
      dout[k*T +: T] = slot_q[k];
    end
  end

  assign bus.dataout = dout;
  assign bus.wr_ack  = ack_q;
  assign bus.update  = upd_q;
  assign bus.err     = err_q;

`ifdef PERIF_WR_READBACK_EN
  logic [T-1:0] rd;

  always_comb begin
    rd = '0;
    for (int k = 0; k < R; k++) begin
      if (dec[k]) rd = slot_q[k];
    end
  end

  assign bus.rdback = rd;
`endif

endmodule

// File: tb/tb_perif_write_demux.sv
// Self-checking bench for perif_write_demux (R=2, T=32, N=2).
// Random transfers checked against an array model of the registers.
module tb_perif_write_demux;

  localparam int R = 2;
  localparam int T = 32;
  localparam int N = 2;
  localparam int W = R * T;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  logic [T-1:0] mem [R];

  perif_write_demux_if #(.R(R), .T(T), .N(N)) bif ();

  perif_write_demux #(.R(R), .T(T), .N(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_dout();
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < R; k++) v = v | (W'(mem[k]) << (k * T));
    return v;
  endfunction

  function automatic logic [R-1:0] exp_upd(input int s);
    return (s < R) ? R'(1 << s) : '0;
  endfunction

  // Called at a negedge with the FSM idle; returns at a negedge, idle.
  task automatic xfer(input string tag, input int s,
                      input logic [T-1:0] d, input int hold);
    bif.selection = N'(s);
    bif.datain    = d;
    bif.wr_req    = 1'b1;
    @(negedge clk);
    if (s < R) mem[s] = d;
    check({tag, " ack"}, W'(bif.wr_ack), W'(1'b1));
    check({tag, " upd"}, W'(bif.update), W'(exp_upd(s)));
    check({tag, " err"}, W'(bif.err), W'(s >= R));
    check({tag, " dout"}, bif.dataout, exp_dout());
`ifdef PERIF_WR_READBACK_EN
    check({tag, " rdback"}, W'(bif.rdback),
          (s < R) ? W'(mem[s]) : '0);
`endif
    for (int i = 0; i < hold; i++) begin
      bif.datain    = $urandom;
      bif.selection = N'($urandom_range(0, 3));
      @(negedge clk);
      check({tag, " hold ack"}, W'(bif.wr_ack), W'(1'b1));
      check({tag, " hold upd/err"},
            W'({bif.update, bif.err}), '0);
      check({tag, " hold dout"}, bif.dataout, exp_dout());
    end
    bif.wr_req = 1'b0;
    @(negedge clk);
    check({tag, " rel ack"}, W'(bif.wr_ack), '0);
    check({tag, " rel upd/err"}, W'({bif.update, bif.err}), '0);
    check({tag, " rel dout"}, bif.dataout, exp_dout());
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    for (int k = 0; k < R; k++) mem[k] = '0;
    rst_n         = 1'b0;
    bif.wr_req    = 1'b0;
    bif.selection = '0;
    bif.datain    = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("reset dout", bif.dataout, '0);
    check("reset ack", W'(bif.wr_ack), '0);
    check("reset upd", W'(bif.update), '0);
    check("reset err", W'(bif.err), '0);

    xfer("basic", 1, 32'hDEADBEEF, 1);
    xfer("b2b0", 0, 32'h12345678, 0);
    xfer("b2b1", 1, 32'hA5A5A5A5, 0);
    xfer("held", 0, 32'h0BADC0DE, 9);
    xfer("oor3", 3, 32'hFFFFFFFF, 0);
    xfer("oor2", 2, 32'h55AA55AA, 2);

    for (int i = 0; i < 24; i++) begin
      xfer("rand", $urandom_range(0, 3), $urandom,
           $urandom_range(0, 3));
    end

    // Reset while in ACK.
    bif.selection = '0;
    bif.datain    = 32'hCAFEF00D;
    bif.wr_req    = 1'b1;
    @(negedge clk);
    mem[0] = 32'hCAFEF00D;
    check("mid ack", W'(bif.wr_ack), W'(1'b1));
    check("mid dout", bif.dataout, exp_dout());
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < R; k++) mem[k] = '0;
    check("rst ack", W'(bif.wr_ack), '0);
    check("rst dout", bif.dataout, '0);
    check("rst upd/err", W'({bif.update, bif.err}), '0);
`ifdef PERIF_WR_READBACK_EN
    check("rst rdback", W'(bif.rdback), '0);
`endif
    bif.wr_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post rst ack", W'(bif.wr_ack), '0);
    xfer("post rst", 1, 32'h13579BDF, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
